// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control unit: state sequencing plus state-decoded
// datapath controls, with optional memory handshake waits and extended opcodes.

package mc_control_pkg;

  localparam int unsigned StateW = 4;
  localparam int unsigned OpW    = 6;
  localparam int unsigned SelW   = 2;

  typedef enum logic [StateW-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_BNE    = 4'd12,
    S_LOGEX  = 4'd13,
    S_TRAP   = 4'd15
  } state_e;

  localparam logic [OpW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OpW-1:0] OP_LW    = 6'b100011;
  localparam logic [OpW-1:0] OP_SW    = 6'b101011;
  localparam logic [OpW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OpW-1:0] OP_BNE   = 6'b000101;
  localparam logic [OpW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OpW-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OpW-1:0] OP_ORI   = 6'b001101;
  localparam logic [OpW-1:0] OP_J     = 6'b000010;

  localparam logic [SelW-1:0] ALU_ADD   = 2'b00;
  localparam logic [SelW-1:0] ALU_SUB   = 2'b01;
  localparam logic [SelW-1:0] ALU_FUNCT = 2'b10;
  localparam logic [SelW-1:0] ALU_LOGI  = 2'b11;

  localparam logic [SelW-1:0] SRCB_REG  = 2'b00;
  localparam logic [SelW-1:0] SRCB_FOUR = 2'b01;
  localparam logic [SelW-1:0] SRCB_IMM  = 2'b10;
  localparam logic [SelW-1:0] SRCB_BOFF = 2'b11;

  localparam logic [SelW-1:0] PC_ALU    = 2'b00;
  localparam logic [SelW-1:0] PC_ALUOUT = 2'b01;
  localparam logic [SelW-1:0] PC_JUMP   = 2'b10;

endpackage

module mc_control_fsm
  import mc_control_pkg::*;
#(
  parameter bit MEM_WAIT = 1'b1,
  parameter bit EXT_OPS  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OpW-1:0]      op,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                iord,
  output logic                irwrite,
  output logic                memwrite,
  output logic                memtoreg,
  output logic                regwrite,
  output logic                regdst,
  output logic                alusrca,
  output logic                branch,
  output logic                branch_ne,
  output logic                pcwrite,
  output logic [SelW-1:0]     alusrcb,
  output logic [SelW-1:0]     aluop,
  output logic [SelW-1:0]     pcsrc,
  output logic                illegal,
  output logic [StateW-1:0]   state_o
);

  state_e state_q;
  state_e state_d;
  logic   mem_done;

  // Without the handshake every memory access completes in its first cycle.
  assign mem_done = MEM_WAIT ? mem_ready : 1'b1;

  function automatic state_e decode_next(input logic [OpW-1:0] opc);
    state_e nxt;
    nxt = S_TRAP;
    case (opc)
      OP_RTYPE:       nxt = S_EXEC;
      OP_LW, OP_SW:   nxt = S_MEMADR;
      OP_BEQ:         nxt = S_BEQ;
      OP_ADDI:        nxt = S_ADDIEX;
      OP_J:           nxt = S_JUMP;
      OP_BNE:         if (EXT_OPS) nxt = S_BNE;
      OP_ANDI,
      OP_ORI:         if (EXT_OPS) nxt = S_LOGEX;
      default:        nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded controls.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    iord      = 1'b0;
    irwrite   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    regdst    = 1'b0;
    alusrca   = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    pcwrite   = 1'b0;
    alusrcb   = SRCB_REG;
    aluop     = ALU_ADD;
    pcsrc     = PC_ALU;
    illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        // Reset holds the FSM here; the strobes stay quiet until it releases.
        mem_req = rst_n;
        irwrite = rst_n & mem_done;
        pcwrite = rst_n & mem_done;
        alusrcb = SRCB_FOUR;
        if (mem_done) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = SRCB_BOFF;
        state_d = decode_next(op);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        case (op)
          OP_LW:   state_d = S_MEMRD;
          OP_SW:   state_d = S_MEMWR;
          default: state_d = S_TRAP;
        endcase
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_done) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_done) state_d = S_FETCH;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = ALU_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        alusrca = 1'b1;
        aluop   = ALU_SUB;
        pcsrc   = PC_ALUOUT;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_BNE: begin
        alusrca   = 1'b1;
        aluop     = ALU_SUB;
        pcsrc     = PC_ALUOUT;
        branch_ne = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = S_IWB;
      end
      S_LOGEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        aluop   = ALU_LOGI;
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end
      // An upset into the unused encoding is treated as an illegal instruction.
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  assign state_o = StateW'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: two instances (waits+extended ops, and
// no-wait/base ops) checked cycle by cycle against a state-table model.

module tb_mc_control_fsm;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  // Only the FETCH constant select (alusrcb=01) survives reset.
  localparam logic [17:0] RST_CTRL = {12'b0, 2'b01, 4'b0};

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctrl;
  } exp_t;

  logic clk;
  logic rst_a_n, rst_b_n;
  logic [5:0] op_a, op_b;
  logic mr_a, mr_b;

  logic mem_req_a, iord_a, irwrite_a, memwrite_a, memtoreg_a, regwrite_a, regdst_a;
  logic alusrca_a, branch_a, branch_ne_a, pcwrite_a, illegal_a;
  logic [1:0] alusrcb_a, aluop_a, pcsrc_a;
  logic [3:0] state_a;

  logic mem_req_b, iord_b, irwrite_b, memwrite_b, memtoreg_b, regwrite_b, regdst_b;
  logic alusrca_b, branch_b, branch_ne_b, pcwrite_b, illegal_b;
  logic [1:0] alusrcb_b, aluop_b, pcsrc_b;
  logic [3:0] state_b;

  logic [17:0] ctrl_a, ctrl_b;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   mw_cnt = 0;
  int   pcw_cnt = 0;

  mc_control_fsm #(.MEM_WAIT(1'b1), .EXT_OPS(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .op(op_a), .mem_ready(mr_a),
    .mem_req(mem_req_a), .iord(iord_a), .irwrite(irwrite_a), .memwrite(memwrite_a),
    .memtoreg(memtoreg_a), .regwrite(regwrite_a), .regdst(regdst_a), .alusrca(alusrca_a),
    .branch(branch_a), .branch_ne(branch_ne_a), .pcwrite(pcwrite_a),
    .alusrcb(alusrcb_a), .aluop(aluop_a), .pcsrc(pcsrc_a),
    .illegal(illegal_a), .state_o(state_a)
  );

  mc_control_fsm #(.MEM_WAIT(1'b0), .EXT_OPS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .op(op_b), .mem_ready(mr_b),
    .mem_req(mem_req_b), .iord(iord_b), .irwrite(irwrite_b), .memwrite(memwrite_b),
    .memtoreg(memtoreg_b), .regwrite(regwrite_b), .regdst(regdst_b), .alusrca(alusrca_b),
    .branch(branch_b), .branch_ne(branch_ne_b), .pcwrite(pcwrite_b),
    .alusrcb(alusrcb_b), .aluop(aluop_b), .pcsrc(pcsrc_b),
    .illegal(illegal_b), .state_o(state_b)
  );

  assign ctrl_a = {mem_req_a, iord_a, irwrite_a, memwrite_a, memtoreg_a, regwrite_a,
                   regdst_a, alusrca_a, branch_a, branch_ne_a, pcwrite_a, illegal_a,
                   alusrcb_a, aluop_a, pcsrc_a};
  assign ctrl_b = {mem_req_b, iord_b, irwrite_b, memwrite_b, memtoreg_b, regwrite_b,
                   regdst_b, alusrca_b, branch_b, branch_ne_b, pcwrite_b, illegal_b,
                   alusrcb_b, aluop_b, pcsrc_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word each state must present, straight from the state table.
  function automatic logic [17:0] model(input logic [3:0] s, input logic md);
    logic mreq, io, irw, mw, m2r, rw, rdst, asa, br, brn, pcw, ill;
    logic [1:0] sb, ao, ps;
    {mreq, io, irw, mw, m2r, rw, rdst, asa, br, brn, pcw, ill} = 12'b0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (s)
      4'd0:  begin mreq = 1'b1; irw = md; pcw = md; sb = 2'b01; end
      4'd1:  sb = 2'b11;
      4'd2:  begin asa = 1'b1; sb = 2'b10; end
      4'd3:  begin mreq = 1'b1; io = 1'b1; end
      4'd4:  begin m2r = 1'b1; rw = 1'b1; end
      4'd5:  begin mreq = 1'b1; io = 1'b1; mw = 1'b1; end
      4'd6:  begin asa = 1'b1; ao = 2'b10; end
      4'd7:  begin rdst = 1'b1; rw = 1'b1; end
      4'd8:  begin asa = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1; end
      4'd9:  begin asa = 1'b1; sb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin ps = 2'b10; pcw = 1'b1; end
      4'd12: begin asa = 1'b1; ao = 2'b01; ps = 2'b01; brn = 1'b1; end
      4'd13: begin asa = 1'b1; sb = 2'b10; ao = 2'b11; end
      4'd15: ill = 1'b1;
      default: ;
    endcase
    return {mreq, io, irw, mw, m2r, rw, rdst, asa, br, brn, pcw, ill, sb, ao, ps};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic expect_now(input bit b, input logic [3:0] st, input logic [17:0] ctrl);
    exp_t e;
    sb_q.push_back('{st: st, ctrl: ctrl});
    e = sb_q.pop_front();
    if (b) begin
      chk("state_b", 32'(state_b), 32'(e.st));
      chk("ctrl_b", 32'(ctrl_b), 32'(e.ctrl));
    end else begin
      chk("state_a", 32'(state_a), 32'(e.st));
      chk("ctrl_a", 32'(ctrl_a), 32'(e.ctrl));
    end
  endtask

  // One cycle: drive op/mem_ready at the falling edge, check the current state.
  task automatic step(input bit b, input logic [5:0] o, input logic mr, input logic [3:0] es);
    @(negedge clk);
    if (b) begin op_b = o; mr_b = mr; end
    else   begin op_a = o; mr_a = mr; end
    #1;
    expect_now(b, es, model(es, b ? 1'b1 : mr));
    if (!b) begin
      mw_cnt  += int'(memwrite_a);
      pcw_cnt += int'(pcwrite_a);
    end
  endtask

  task automatic pulse_reset(input bit b);
    @(negedge clk);
    if (b) rst_b_n = 1'b0; else rst_a_n = 1'b0;
    #1;
    expect_now(b, 4'd0, RST_CTRL);
  endtask

  task automatic release_rst(input bit b, input logic [5:0] o, input logic mr);
    @(negedge clk);
    if (b) begin rst_b_n = 1'b1; op_b = o; mr_b = mr; end
    else   begin rst_a_n = 1'b1; op_a = o; mr_a = mr; end
    #1;
    expect_now(b, 4'd0, model(4'd0, b ? 1'b1 : mr));
  endtask

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    op_a = LW; op_b = LW; mr_a = 1'b1; mr_b = 1'b1;
    #3;
    expect_now(0, 4'd0, RST_CTRL);
    expect_now(1, 4'd0, RST_CTRL);
    @(negedge clk); #1;
    expect_now(0, 4'd0, RST_CTRL);

    // LW with fetch and read waits; op changes after MEMADR are ignored.
    release_rst(0, LW, 1'b0);
    step(0, LW, 1'b1, 4'd0);
    step(0, LW, 1'b1, 4'd1);
    step(0, LW, 1'b1, 4'd2);
    step(0, SW, 1'b0, 4'd3);
    step(0, SW, 1'b0, 4'd3);
    step(0, SW, 1'b1, 4'd3);
    step(0, SW, 1'b1, 4'd4);

    // SW with mem_ready low for three MEMWR cycles.
    mw_cnt = 0; pcw_cnt = 0;
    step(0, SW, 1'b1, 4'd0);
    step(0, SW, 1'b1, 4'd1);
    step(0, SW, 1'b1, 4'd2);
    step(0, SW, 1'b0, 4'd5);
    step(0, SW, 1'b0, 4'd5);
    step(0, SW, 1'b0, 4'd5);
    step(0, RT, 1'b1, 4'd5);
    chk("sw_memwrite_cycles", 32'(mw_cnt), 32'd4);
    chk("sw_pcwrite_pulses", 32'(pcw_cnt), 32'd1);

    // R-type, with op disturbed in EXEC.
    step(0, RT, 1'b1, 4'd0);
    step(0, RT, 1'b1, 4'd1);
    step(0, BEQ, 1'b1, 4'd6);
    step(0, ADDI, 1'b1, 4'd7);
    // ADDI, ANDI, ORI
    step(0, ADDI, 1'b1, 4'd0);
    step(0, ADDI, 1'b1, 4'd1);
    step(0, ADDI, 1'b1, 4'd9);
    step(0, ANDI, 1'b1, 4'd10);
    step(0, ANDI, 1'b1, 4'd0);
    step(0, ANDI, 1'b1, 4'd1);
    step(0, ANDI, 1'b1, 4'd13);
    step(0, ORI, 1'b1, 4'd10);
    step(0, ORI, 1'b1, 4'd0);
    step(0, ORI, 1'b1, 4'd1);
    step(0, ORI, 1'b1, 4'd13);
    step(0, BEQ, 1'b1, 4'd10);
    // BEQ, BNE, J
    step(0, BEQ, 1'b1, 4'd0);
    step(0, BEQ, 1'b1, 4'd1);
    step(0, BNE, 1'b1, 4'd8);
    step(0, BNE, 1'b1, 4'd0);
    step(0, BNE, 1'b1, 4'd1);
    step(0, JMP, 1'b1, 4'd12);
    step(0, JMP, 1'b1, 4'd0);
    step(0, JMP, 1'b1, 4'd1);
    step(0, JMP, 1'b1, 4'd11);
    // Undefined opcode traps and holds even through fetch-looking inputs.
    step(0, BAD, 1'b1, 4'd0);
    step(0, BAD, 1'b1, 4'd1);
    step(0, LW, 1'b1, 4'd15);
    step(0, LW, 1'b1, 4'd15);
    step(0, LW, 1'b1, 4'd15);
    pulse_reset(0);

    // Asynchronous reset mid-cycle while MEMRD waits for memory.
    release_rst(0, LW, 1'b1);
    step(0, LW, 1'b1, 4'd1);
    step(0, LW, 1'b1, 4'd2);
    step(0, LW, 1'b0, 4'd3);
    #2;
    rst_a_n = 1'b0;
    #1;
    expect_now(0, 4'd0, RST_CTRL);
    @(negedge clk); #1;
    expect_now(0, 4'd0, RST_CTRL);
    release_rst(0, RT, 1'b1);
    step(0, RT, 1'b1, 4'd1);
    step(0, RT, 1'b1, 4'd6);
    step(0, RT, 1'b1, 4'd7);
    step(0, RT, 1'b0, 4'd0);

    // Upset into unused encoding 14 must steer to TRAP.
    force dut_a.state_q = mc_control_pkg::state_e'(4'd14);
    #1;
    chk("upset_state", 32'(state_a), 32'd14);
    chk("upset_ctrl", 32'(ctrl_a), 32'd0);
    chk("upset_next", 32'(dut_a.state_d), 32'd15);
    release dut_a.state_q;
    pulse_reset(0);

    // No-wait, base-opcode instance: LW and SW with mem_ready held low.
    release_rst(1, LW, 1'b0);
    step(1, LW, 1'b0, 4'd1);
    step(1, LW, 1'b0, 4'd2);
    step(1, LW, 1'b0, 4'd3);
    step(1, LW, 1'b0, 4'd4);
    step(1, SW, 1'b0, 4'd0);
    step(1, SW, 1'b0, 4'd1);
    step(1, SW, 1'b0, 4'd2);
    step(1, SW, 1'b0, 4'd5);
    // BNE is illegal without extended ops; trap holds for ten cycles.
    step(1, BNE, 1'b0, 4'd0);
    step(1, BNE, 1'b0, 4'd1);
    for (int i = 0; i < 10; i++) step(1, BNE, 1'b0, 4'd15);
    pulse_reset(1);
    release_rst(1, ORI, 1'b0);
    step(1, ORI, 1'b0, 4'd1);
    step(1, ORI, 1'b0, 4'd15);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter MEM_WAIT, default 1, meaning: 1 = memory states wait on mem_ready; 0 = mem_ready ignored and treated as 1.
REQ-002 Parameter EXT_OPS, default 1, meaning: 1 = BNE/ANDI/ORI decoded; 0 = those opcodes are illegal.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 op  in  6  instruction opcode from instruction register.
REQ-006 mem_ready  in  1  memory completes current access this cycle.
REQ-007 mem_req  out  1  memory access requested.
REQ-008 iord, irwrite, memwrite, memtoreg, regwrite, regdst, alusrca  out  1 each  datapath controls.
REQ-009 branch, branch_ne  out  1 each  conditional PC write on zero / not-zero.
REQ-010 pcwrite  out  1  unconditional PC write.
REQ-011 alusrcb, aluop, pcsrc  out  2 each  datapath selects; aluop 00 add, 01 sub, 10 funct, 11 logic-immediate.
REQ-012 illegal  out  1  trap flag.
REQ-013 state_o  out  4  current state encoding, for debug.

Function
REQ-014 States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BEQ 8, ADDIEX 9, IWB 10, JUMP 11, BNE 12, LOGEX 13, TRAP 15; 14 unused.
REQ-015 Outputs are decoded combinationally from state (plus mem_ready where stated); every output not listed for a state is 0.
REQ-016 FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=mem_ready-qualified; advance to DECODE only when mem_ready=1, else hold.
REQ-017 DECODE: alusrca=0, alusrcb=11, aluop=00; next: 000000->EXEC, 100011/101011->MEMADR, 000100->BEQ, 001000->ADDIEX, 000010->JUMP; with EXT_OPS=1, 000101->BNE, 001100/001101->LOGEX; any other opcode->TRAP.
REQ-018 MEMADR: alusrca=1, alusrcb=10, aluop=00; LW->MEMRD, SW->MEMWR.
REQ-019 MEMRD: mem_req=1, iord=1; hold until mem_ready, then MEMWB.
REQ-020 MEMWB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
REQ-021 MEMWR: mem_req=1, iord=1, memwrite=1 (held while waiting); on mem_ready -> FETCH.
REQ-022 EXEC: alusrca=1, alusrcb=00, aluop=10 -> ALUWB; ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
REQ-023 ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> IWB; LOGEX: same with aluop=11 -> IWB; IWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
REQ-024 BEQ: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 -> FETCH; BNE identical except branch_ne=1, branch=0.
REQ-025 JUMP: pcsrc=10, pcwrite=1 -> FETCH.
REQ-026 TRAP: illegal=1, all other controls 0, mem_req=0; state held until reset.
REQ-027 Unused encoding 14 (upset) -> TRAP next cycle.
REQ-028 With MEM_WAIT=0, FETCH/MEMRD/MEMWR each last exactly one cycle regardless of mem_ready.
REQ-029 op is sampled only in DECODE and MEMADR; changes in other states have no effect.
REQ-030 Cycle counts (no waits): LW 5, SW 4, R-type 4, ADDI/ANDI/ORI 4, BEQ/BNE 3, J 3.

Reset
REQ-031 rst_n=0 forces state FETCH immediately, asynchronously, including mid-instruction and during memory wait.
REQ-032 While rst_n=0 all outputs are 0 except FETCH's static selects (alusrcb=01); irwrite/pcwrite/mem_req are 0 during reset.
REQ-033 First FETCH request occurs in the first clk edge cycle after rst_n deasserts.

Verification
REQ-034 MEM_WAIT=0, op=100011 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-035 MEM_WAIT=1, op=101011, mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH; single pcwrite pulse per instruction.
REQ-036 EXT_OPS=0, op=000101 -> DECODE then TRAP, illegal=1 held 10 cycles; rst_n pulse -> FETCH, illegal=0.
REQ-037 EXT_OPS=1, op=000101 -> BNE with branch_ne=1, branch=0, aluop=01, pcsrc=01; op=001101 -> LOGEX aluop=11 then IWB regwrite=1, regdst=0.
REQ-038 Assert rst_n=0 mid-cycle while in MEMRD awaiting mem_ready -> state_o=0 before next edge, mem_req=0 while in reset.
REQ-039 op=000010 -> JUMP with pcsrc=10, pcwrite=1, 3-cycle instruction; force state 14 -> TRAP next edge.
